// File: rtl/trap_ctrl.sv
// Trap/interrupt entry controller: captures irq edges and syscall pulses, handshakes
// trap entry with the core and pulses to_kernel_o. Optional macro: TRAP_ACK_TIMEOUT_EN.
module trap_ctrl #(
    parameter int IRQ_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [IRQ_W-1:0] irq_i,
    input  logic [IRQ_W-1:0] irq_mask_i,
    input  logic [31:0]      flags_i,
    input  logic             sw_trap_i,
    input  logic             ack_i,
    input  logic             eoi_i,
    output logic             trap_req_o,
    output logic [7:0]       trap_cause_o,
    output logic             to_kernel_o,
    output logic             busy_o,
    output logic [IRQ_W-1:0] pending_o,
    output logic             timeout_o
);
    typedef enum logic [1:0] {IDLE, REQ, ENTER, IN_TRAP} state_e;

    state_e                                state_q;
    logic [SYNC_STAGES-1:0][IRQ_W-1:0]     sync_q;
    logic [IRQ_W-1:0]                      prev_q, pend_q, rise, eligible, clr;
    logic [7:0]                            cause_q;
    logic [6:0]                            low_idx;
    logic                                  req_q, to_kernel_q, busy_q, timeout_q;
    logic                                  unused_flags;

    assign unused_flags = ^flags_i[31:1];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= (pend_q & ~clr) | rise;   // capture beats clear
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign eligible = pend_q & irq_mask_i;

    always_comb begin
        low_idx = '0;
        for (int i = IRQ_W - 1; i >= 0; i--)
            if (eligible[i]) low_idx = 7'(i);
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < IRQ_W; i++)
            clr[i] = (state_q == ENTER) && cause_q[7] && (cause_q[6:0] == 7'(i));
    end

`ifdef TRAP_ACK_TIMEOUT_EN
    localparam int CW = (ACK_TIMEOUT > 255) ? $clog2(ACK_TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          expire;
    assign expire = (cnt_q == CW'(ACK_TIMEOUT - 1));
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            req_q       <= 1'b0;
            to_kernel_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef TRAP_ACK_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // KF set: syscall pulse is dropped, irqs simply stay pending
                    if (!flags_i[0] && (sw_trap_i || (|eligible))) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cause_q <= sw_trap_i ? 8'h00 : {1'b1, low_idx};
`ifdef TRAP_ACK_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        state_q     <= ENTER;
                        req_q       <= 1'b0;
                        to_kernel_q <= 1'b1;
`ifdef TRAP_ACK_TIMEOUT_EN
                    end else if (expire) begin
                        state_q     <= ENTER;
                        req_q       <= 1'b0;
                        to_kernel_q <= 1'b1;
                        timeout_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ENTER: begin
                    state_q     <= IN_TRAP;
                    to_kernel_q <= 1'b0;
                end
                IN_TRAP: begin
                    if (eoi_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        cause_q   <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trap_req_o   = req_q;
    assign trap_cause_o = cause_q;
    assign to_kernel_o  = to_kernel_q;
    assign busy_o       = busy_q;
    assign pending_o    = pend_q;
    assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed test-plan sequences plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_trap_ctrl;
    localparam int IRQ_W  = 8;
    localparam int SYNC   = 2;
    localparam int ACK_TO = 4;
`ifdef TRAP_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_REQ = 1, P_ENTER = 2, P_TRAP = 3;

    logic             clk_i = 1'b0, arst_ni = 1'b0;
    logic [IRQ_W-1:0] irq_i = '0, irq_mask_i = '1;
    logic [31:0]      flags_i = '0;
    logic             sw_trap_i = 1'b0, ack_i = 1'b0, eoi_i = 1'b0;
    logic             trap_req_o, to_kernel_o, busy_o, timeout_o;
    logic [7:0]       trap_cause_o;
    logic [IRQ_W-1:0] pending_o;

    trap_ctrl #(.IRQ_W(IRQ_W), .SYNC_STAGES(SYNC), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .irq_i(irq_i), .irq_mask_i(irq_mask_i),
        .flags_i(flags_i), .sw_trap_i(sw_trap_i), .ack_i(ack_i), .eoi_i(eoi_i),
        .trap_req_o(trap_req_o), .trap_cause_o(trap_cause_o), .to_kernel_o(to_kernel_o),
        .busy_o(busy_o), .pending_o(pending_o), .timeout_o(timeout_o));

    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: phase of the current trap, its cause, and the pending set
    int               ph, m_wait;
    logic [7:0]       m_cause;
    logic [IRQ_W-1:0] m_pend;
    logic             m_to;
    logic [IRQ_W-1:0] hist [0:SYNC+1];

    function automatic int lowest(input logic [IRQ_W-1:0] v);
        for (int i = 0; i < IRQ_W; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; m_wait = 0; m_cause = '0; m_pend = '0; m_to = 1'b0;
        for (int j = 0; j <= SYNC + 1; j++) hist[j] = '0;
    endtask

    task automatic model_step();
        logic [IRQ_W-1:0] rise, elig, clr;
        for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = irq_i;
        rise = hist[SYNC] & ~hist[SYNC+1];
        elig = m_pend & irq_mask_i;
        clr  = '0;
        if (ph == P_ENTER && m_cause[7]) clr[m_cause[2:0]] = 1'b1;
        case (ph)
            P_IDLE: if (!flags_i[0]) begin
                if (sw_trap_i) begin m_cause = 8'h00; ph = P_REQ; m_wait = 0; end
                else if (elig != 0) begin m_cause = 8'h80 | 8'(lowest(elig)); ph = P_REQ; m_wait = 0; end
            end
            P_REQ: begin
                if (ack_i) ph = P_ENTER;
                else if (TO_EN && m_wait + 1 == ACK_TO) begin ph = P_ENTER; m_to = 1'b1; end
                else m_wait++;
            end
            P_ENTER: ph = P_TRAP;
            default: if (eoi_i) begin ph = P_IDLE; m_cause = '0; m_to = 1'b0; end
        endcase
        m_pend = (m_pend & ~clr) | rise;
    endtask

    task automatic compare_all();
        chk("trap_req",  64'(trap_req_o),   64'(ph == P_REQ));
        chk("to_kernel", 64'(to_kernel_o),  64'(ph == P_ENTER));
        chk("busy",      64'(busy_o),       64'(ph != P_IDLE));
        chk("cause",     64'(trap_cause_o), 64'(m_cause));
        chk("pending",   64'(pending_o),    64'(m_pend));
        chk("timeout",   64'(timeout_o),    64'(m_to));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        if (arst_ni) model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_req(input string tag, input logic [7:0] exp_cause);
        int n = 0;
        while (!trap_req_o && n < 30) begin cyc(); n++; end
        chk({tag, "_req_seen"}, 64'(trap_req_o), 64'd1);
        chk({tag, "_cause"}, 64'(trap_cause_o), 64'(exp_cause));
    endtask

    task automatic ack_and_eoi(input string tag);
        ack_i = 1'b1; cyc(); ack_i = 1'b0;
        chk({tag, "_to_kernel"}, 64'(to_kernel_o), 64'd1);
        cyc();
        chk({tag, "_to_kernel_off"}, 64'(to_kernel_o), 64'd0);
        eoi_i = 1'b1; cyc(); eoi_i = 1'b0;
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        model_reset();
        #22 arst_ni = 1'b1;
        #1 compare_all();
        for (int i = 0; i < 10; i++) cyc();

        // two irqs, lowest first, then the next
        irq_i = 8'h24;
        cyc(); cyc(); cyc();
        chk("pend_latency", 64'(pending_o), 64'h24);
        wait_req("irq2", 8'h82);
        ack_and_eoi("irq2");
        chk("pend_after_irq2", 64'(pending_o), 64'h20);
        wait_req("irq5", 8'h85);
        ack_and_eoi("irq5");
        irq_i = '0;
        for (int i = 0; i < 4; i++) cyc();

        // syscall beats a simultaneously eligible irq 0
        irq_i = 8'h01;
        cyc(); cyc(); cyc();
        sw_trap_i = 1'b1; cyc(); sw_trap_i = 1'b0;
        chk("sw_cause", 64'(trap_cause_o), 64'h00);
        chk("sw_irq_pending", 64'(pending_o), 64'h01);
        ack_and_eoi("sw");
        wait_req("irq0", 8'h80);
        ack_and_eoi("irq0");
        irq_i = '0;
        for (int i = 0; i < 4; i++) cyc();

        // kernel mode: syscall dropped, irq held pending
        flags_i = 32'h1;
        sw_trap_i = 1'b1; cyc(); sw_trap_i = 1'b0;
        irq_i = 8'h01;
        for (int i = 0; i < 6; i++) cyc();
        chk("kf_no_req", 64'(trap_req_o), 64'd0);
        chk("kf_pending", 64'(pending_o), 64'h01);
        flags_i = 32'h0;
        wait_req("kf_release", 8'h80);
        ack_and_eoi("kf_release");
        irq_i = '0;

        // masked pending, then unmask, then reset in REQ
        irq_mask_i = 8'h00;
        irq_i = 8'h10;
        for (int i = 0; i < 8; i++) cyc();
        chk("masked_no_req", 64'(trap_req_o), 64'd0);
        chk("masked_pending", 64'(pending_o), 64'h10);
        irq_mask_i = 8'h10;
        wait_req("unmask", 8'h84);
        arst_ni = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk_i); #1;
        chk("rst_no_to_kernel", 64'(to_kernel_o), 64'd0);
        irq_i = '0; irq_mask_i = '1;
        @(negedge clk_i) arst_ni = 1'b1;
        cyc();

`ifdef TRAP_ACK_TIMEOUT_EN
        begin
            int n = 0;
            sw_trap_i = 1'b1; cyc(); sw_trap_i = 1'b0;
            while (!to_kernel_o && n < 20) begin cyc(); n++; end
            chk("to_req_cycles", 64'(n), 64'(ACK_TO));
            chk("to_flag", 64'(timeout_o), 64'd1);
            cyc(); cyc();
            chk("to_sticky", 64'(timeout_o), 64'd1);
            eoi_i = 1'b1; cyc(); eoi_i = 1'b0;
            chk("to_cleared", 64'(timeout_o), 64'd0);
        end
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            irq_i     = irq_i ^ (IRQ_W'($urandom) & IRQ_W'($urandom) & IRQ_W'($urandom));
            if ($urandom_range(0, 49) == 0) irq_mask_i = IRQ_W'($urandom);
            flags_i   = {$urandom, 1'b0} | 32'($urandom_range(0, 4) == 0);
            sw_trap_i = ($urandom_range(0, 9) == 0);
            ack_i     = ($urandom_range(0, 3) == 0);
            eoi_i     = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
